memory_arbiter: RTL

- Shares the single coprocessor memory port between num_requesters control units. Each unit raises a grant request and holds it for its whole burst.
- Arbitration is round-robin. Exactly one grant is active at a time, and the granted unit's address and enables are steered to memory.
- Sits between the per-block control units and the memory. Each unit's o_Grant_Request/i_Grant pair connects here.

---
 rtl/memory_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin owner of the single coprocessor memory port.
// A unit raises its request, is granted one-hot, keeps the grant for as long
// as it holds its request, and gets its address/enables steered to memory.
// Two sticky flags report an over-long burst and any enable raised by a unit
// that does not currently own the port.
//
// Handshake: a unit raises i_Grant_Request[n] and holds it for the whole burst.
// The grant (o_Grant[n]) appears after the first edge that sees the request in
// IDLE. The unit may drive its enables only while its own o_Grant bit is 1, and
// it drops its request after its final access cycle. The grant clears on the
// edge that sees the owner's request low, and the port is re-arbitrated one
// edge later, so consecutive grants are separated by exactly one idle cycle.
module memory_arbiter #(
    parameter int num_requesters     = 4,
    parameter int num_requesters_log = 2,
    parameter int memory_size_log    = 10,
    parameter int max_hold           = 64
) (
    input  logic                                      i_Clock,
    input  logic                                      i_Reset,
    input  logic [num_requesters-1:0]                 i_Grant_Request,
    output logic [num_requesters-1:0]                 o_Grant,
    input  logic [num_requesters*memory_size_log-1:0] i_Memory_Address,
    input  logic [num_requesters-1:0]                 i_Memory_Write_Enable,
    input  logic [num_requesters-1:0]                 i_Memory_Read_Enable,
    output logic [memory_size_log-1:0]                o_Memory_Address,
    output logic                                      o_Memory_Write_Enable,
    output logic                                      o_Memory_Read_Enable,
    output logic [num_requesters_log-1:0]             o_Owner,
    output logic                                      o_Busy,
    output logic                                      o_Hold_Violation,
    output logic                                      o_Protocol_Error
);

    // Hold counter must be able to represent max_hold itself (it saturates there).
    localparam int hold_w = $clog2(max_hold + 1);
    localparam logic [hold_w-1:0] hold_limit = hold_w'(max_hold);
    // Pointer reset value: the highest index, so unit 0 wins the first scan.
    localparam logic [num_requesters_log-1:0] last_reset = num_requesters_log'(num_requesters - 1);

    typedef enum logic {
        state_idle    = 1'b0,
        state_granted = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [num_requesters-1:0]       grant_q, grant_d;
    logic [num_requesters_log-1:0]   owner_q, owner_d;
    logic [num_requesters_log-1:0]   last_q, last_d;
    logic [hold_w-1:0]               hold_cnt_q, hold_cnt_d;
    logic                            hold_viol_q, hold_viol_d;
    logic                            proto_err_q, proto_err_d;

    // Arbitration scan results.
    int                              scan_int;
    logic [num_requesters_log-1:0]   scan_idx;
    logic                            arb_found;
    logic [num_requesters_log-1:0]   arb_winner;

    logic                            busy;
    logic                            owner_req;
    logic [hold_w-1:0]               hold_sat;
    logic                            bad_enable;

    // The FSM state is directly visible as o_Busy (GRANTED <=> busy).
    assign busy      = (state_q == state_granted);
    assign owner_req = i_Grant_Request[owner_q];
    assign hold_sat  = (hold_cnt_q == hold_limit) ? hold_cnt_q : hold_cnt_q + hold_w'(1);

    // Round-robin scan: first requester at last+1, last+2, ... with wrap-around.
    always_comb begin
        arb_found  = 1'b0;
        arb_winner = last_q;
        scan_int   = 0;
        scan_idx   = '0;
        for (int i = 1; i <= num_requesters; i++) begin
            scan_int = int'(last_q) + i;
            if (scan_int >= num_requesters) begin
                scan_int = scan_int - num_requesters;
            end
            scan_idx = num_requesters_log'(scan_int);
            if (!arb_found && i_Grant_Request[scan_idx]) begin
                arb_found  = 1'b1;
                arb_winner = scan_idx;
            end
        end
    end

    // Any enable from a unit that is not the current owner is a protocol error
    // (while IDLE nobody owns the port, so every enable counts).
    always_comb begin
        bad_enable = 1'b0;
        for (int n = 0; n < num_requesters; n++) begin
            if ((i_Memory_Write_Enable[n] || i_Memory_Read_Enable[n]) &&
                !(busy && (owner_q == num_requesters_log'(n)))) begin
                bad_enable = 1'b1;
            end
        end
    end

    // Memory port mux: only the owner's slice ever reaches memory.
    always_comb begin
        o_Memory_Address      = '0;
        o_Memory_Write_Enable = 1'b0;
        o_Memory_Read_Enable  = 1'b0;
        for (int n = 0; n < num_requesters; n++) begin
            if (busy && (owner_q == num_requesters_log'(n))) begin
                o_Memory_Address      = i_Memory_Address[n*memory_size_log +: memory_size_log];
                o_Memory_Write_Enable = i_Memory_Write_Enable[n];
                o_Memory_Read_Enable  = i_Memory_Read_Enable[n];
            end
        end
    end

    // Next-state logic: grant in IDLE, hold/release in GRANTED, sticky flags.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        last_d      = last_q;
        hold_cnt_d  = hold_cnt_q;
        hold_viol_d = hold_viol_q;
        proto_err_d = proto_err_q | bad_enable;
        case (state_q)
            state_idle: begin
                if (arb_found) begin
                    state_d             = state_granted;
                    grant_d             = '0;
                    grant_d[arb_winner] = 1'b1;
                    owner_d             = arb_winner;
                    last_d              = arb_winner;
                    hold_cnt_d          = '0;
                end
            end
            state_granted: begin
                if (owner_req) begin
                    // No preemption: other requests are ignored while owned.
                    hold_cnt_d = hold_sat;
                    if (hold_sat == hold_limit) begin
                        hold_viol_d = 1'b1;
                    end
                end else begin
                    // Release wins over any pending requests; they are
                    // arbitrated on the following edge.
                    state_d = state_idle;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = state_idle;
                grant_d = '0;
            end
        endcase
    end

    // State register with asynchronous reset.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q     <= state_idle;
            grant_q     <= '0;
            owner_q     <= '0;
            last_q      <= last_reset;
            hold_cnt_q  <= '0;
            hold_viol_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            hold_cnt_q  <= hold_cnt_d;
            hold_viol_q <= hold_viol_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign o_Grant          = grant_q;
    assign o_Owner          = owner_q;
    assign o_Busy           = busy;
    assign o_Hold_Violation = hold_viol_q;
    assign o_Protocol_Error = proto_err_q;

endmodule
